// File: rtl/apb_fifo_pkg.sv
// Shared types and register map for the multi-channel APB FIFO slave.
// Channel index lives in PADDR[7:4], register offset in PADDR[3:0].
package apb_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] REG_DATA_WR = 4'h1;
  localparam logic [3:0] REG_DATA_RD = 4'h2;
  localparam logic [3:0] REG_STATUS  = 4'h3;
  localparam logic [3:0] REG_ERR     = 4'h4;

  localparam int ERR_OVF_BIT   = 0;
  localparam int ERR_UDF_BIT   = 1;
  localparam int STS_EMPTY_BIT = 0;
  localparam int STS_FULL_BIT  = 1;

  // Address decode always spans 16 channel slots; unused slots read as zero.
  localparam int MAX_CH = 16;

endpackage

// File: rtl/apb_fifo_ch_err.sv
// Sticky overflow/underflow flags for one channel, cleared by write-one.
// A new error in the same cycle as its clear keeps the flag set.
module apb_fifo_ch_err (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set_ovf,
  input  logic i_set_udf,
  input  logic i_clr_ovf,
  input  logic i_clr_udf,
  output logic o_ovf,
  output logic o_udf
);

  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= i_set_ovf | (r_ovf & ~i_clr_ovf);
      r_udf <= i_set_udf | (r_udf & ~i_clr_udf);
    end
  end

  assign o_ovf = r_ovf;
  assign o_udf = r_udf;

endmodule

// File: rtl/apb_fifo_mc_slave.sv
// APB3 slave front-end for a bank of NUM_CH FIFOs: push/pop/status/error
// registers per channel, programmable wait states and PSLVERR reporting.
module apb_fifo_mc_slave
  import apb_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_CH   = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [DATA_W-1:0]        PWDATA,
  output logic                     PREADY,
  output logic [DATA_W-1:0]        PRDATA,
  output logic                     PSLVERR,
  input  logic [NUM_CH-1:0]        fifo_full,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_rdata,
  output logic [NUM_CH-1:0]        fifo_wr,
  output logic [NUM_CH-1:0]        fifo_rd,
  output logic [DATA_W-1:0]        fifo_wdata
);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wait_cnt;
  logic        w_done;

  logic [3:0]  w_ch;
  logic [3:0]  w_reg;
  logic        w_ch_ok;

  logic [MAX_CH-1:0] w_full;
  logic [MAX_CH-1:0] w_empty;
  logic [MAX_CH-1:0] w_ovf;
  logic [MAX_CH-1:0] w_udf;
  logic [DATA_W-1:0] w_rdata [MAX_CH];

  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_udf_evt;
  logic w_err_clr;

  assign w_ch       = PADDR[7:4];
  assign w_reg      = PADDR[3:0];
  assign w_ch_ok    = (PADDR[ADDR_W-1:8] == '0) && ({28'd0, w_ch} < 32'(NUM_CH));
  assign fifo_wdata = PWDATA;

  // Completion needs PSEL still high so a dropped select never strobes.
  assign w_done = (r_state == ACCESS) && PSEL && (r_wait_cnt == 4'(WAIT_CYC));

  // Per-channel fan-out; slots beyond NUM_CH are tied off so decode can index all 16.
  generate
    for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_ch
        logic w_hit;
        assign w_hit       = (w_ch == 4'(gi));
        assign w_full[gi]  = fifo_full[gi];
        assign w_empty[gi] = fifo_empty[gi];
        assign w_rdata[gi] = fifo_rdata[gi*DATA_W +: DATA_W];
        assign fifo_wr[gi] = w_push_ok & w_hit;
        assign fifo_rd[gi] = w_pop_ok & w_hit;

        apb_fifo_ch_err u_err (
          .clk       (PCLK),
          .rst_n     (PRESET),
          .i_set_ovf (w_ovf_evt & w_hit),
          .i_set_udf (w_udf_evt & w_hit),
          .i_clr_ovf (w_err_clr & w_hit & PWDATA[ERR_OVF_BIT]),
          .i_clr_udf (w_err_clr & w_hit & PWDATA[ERR_UDF_BIT]),
          .o_ovf     (w_ovf[gi]),
          .o_udf     (w_udf[gi])
        );
      end else begin : g_pad
        assign w_full[gi]  = 1'b0;
        assign w_empty[gi] = 1'b0;
        assign w_rdata[gi] = '0;
        assign w_ovf[gi]   = 1'b0;
        assign w_udf[gi]   = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) w_state_next = SETUP;
      end
      SETUP: begin
        if (!PSEL)        w_state_next = IDLE;
        else if (PENABLE) w_state_next = ACCESS;
      end
      ACCESS: begin
        if (!PSEL)       w_state_next = IDLE;
        else if (w_done) w_state_next = PENABLE ? IDLE : SETUP;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == ACCESS) && PSEL && (r_wait_cnt != 4'(WAIT_CYC))) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  always_comb begin
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    w_err_clr = 1'b0;
    if (w_done) begin
      PREADY = 1'b1;
      if (!w_ch_ok) begin
        PSLVERR = 1'b1;
      end else begin
        case (w_reg)
          REG_DATA_WR: begin
            if (!PWRITE) begin
              PSLVERR = 1'b1;
            end else if (w_full[w_ch]) begin
              PSLVERR   = 1'b1;
              w_ovf_evt = 1'b1;
            end else begin
              w_push_ok = 1'b1;
            end
          end
          REG_DATA_RD: begin
            if (PWRITE) begin
              PSLVERR = 1'b1;
            end else begin
              // Head data is returned even on underflow; the error flag qualifies it.
              PRDATA = w_rdata[w_ch];
              if (w_empty[w_ch]) begin
                PSLVERR   = 1'b1;
                w_udf_evt = 1'b1;
              end else begin
                w_pop_ok = 1'b1;
              end
            end
          end
          REG_STATUS: begin
            if (PWRITE) begin
              PSLVERR = 1'b1;
            end else begin
              PRDATA[STS_EMPTY_BIT] = w_empty[w_ch];
              PRDATA[STS_FULL_BIT]  = w_full[w_ch];
            end
          end
          REG_ERR: begin
            if (PWRITE) begin
              w_err_clr = 1'b1;
            end else begin
              PRDATA[ERR_OVF_BIT] = w_ovf[w_ch];
              PRDATA[ERR_UDF_BIT] = w_udf[w_ch];
            end
          end
          default: PSLVERR = 1'b1;
        endcase
      end
    end
  end

endmodule
